// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package imem_dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Starvation count width; STARVE_MAX must fit, so it is limited to 255.
  localparam int unsigned STARVE_W = 8;

endpackage

// File: rtl/imem_dmem_arbiter_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_cnt
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  output logic                at_max,
  output logic [STARVE_W-1:0] count
);

  logic [STARVE_W-1:0] count_q;

  assign at_max = (count_q == STARVE_W'(STARVE_MAX));
  assign count  = count_q;

  // clr wins over inc so that a fetch grant always restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && !at_max) begin
      count_q <= count_q + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// with data priority and a forced fetch after STARVE_MAX back-to-back data grants.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_read,
  input  logic                dm_write,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output arb_state_e          dbg_state_o,
  output logic [STARVE_W-1:0] dbg_starve_o
);

  // Handshakes: requesters hold if_req / dm_read / dm_write (and their address and
  // data) until their one-cycle ready pulse. Toward memory, mem_req and every mem_*
  // output stay stable from grant until the cycle mem_ack is high; mem_rdata is
  // sampled only in that cycle, and mem_ack outside FETCH/DATA is ignored.

  arb_state_e          state_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, if_rdata_q, dm_rdata_q;
  logic                if_ready_q, dm_ready_q;

  logic dm_req, at_max, grant_data, grant_fetch, starve_inc, starve_clr;
  logic [STARVE_W-1:0] starve_count;

  assign dm_req      = dm_read | dm_write;
  assign grant_data  = (state_q == IDLE) && dm_req && !(if_req && at_max);
  assign grant_fetch = (state_q == IDLE) && !grant_data && if_req;
  assign starve_inc  = grant_data && if_req;
  assign starve_clr  = grant_fetch || ((state_q == IDLE) && !if_req);

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .at_max(at_max),
    .count (starve_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            // A simultaneous read and write is served as a write.
            state_q     <= DATA;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_write;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
          end else if (grant_fetch) begin
            state_q    <= FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            state_q    <= DONE;
            mem_req_q  <= 1'b0;
            if_rdata_q <= mem_rdata;
            if_ready_q <= 1'b1;
          end
        end
        DATA: begin
          if (mem_ack) begin
            state_q    <= DONE;
            mem_req_q  <= 1'b0;
            dm_ready_q <= 1'b1;
            if (!mem_we_q) begin
              dm_rdata_q <= mem_rdata;
            end
          end
        end
        // DONE gives the requester one cycle to drop its request before re-arbitration.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign if_rdata     = if_rdata_q;
  assign dm_rdata     = dm_rdata_q;
  assign if_ready     = if_ready_q;
  assign dm_ready     = dm_ready_q;
  assign stall_if     = if_req & ~if_ready_q;
  assign stall_mem    = dm_req & ~dm_ready_q;
  assign dbg_state_o  = state_q;
  assign dbg_starve_o = starve_count;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: vector table, concurrent-request
// sequences, reset abort, and a scoreboard fed by the ready pulses.
module tb_imem_dmem_arbiter;
  import imem_dmem_arbiter_pkg::*;

  localparam int K_FETCH = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BOTH  = 3;

  logic        clk, reset;
  logic        if_req, if_ready, dm_read, dm_write, dm_ready;
  logic [7:0]  if_addr, dm_addr, mem_addr;
  logic [31:0] if_rdata, dm_rdata, dm_wdata, mem_wdata, mem_rdata;
  logic        stall_if, stall_mem, mem_req, mem_we, mem_ack;
  arb_state_e  dbg_state;
  logic [7:0]  dbg_starve;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_m [256];
  int          lat_cfg    = 1;
  bit          ack_en     = 1'b1;
  bit          manual_ack = 1'b0;

  logic [31:0] if_exp_q[$];
  logic [31:0] dm_exp_q[$];
  logic [7:0]  grant_q[$];
  logic [7:0]  starve_q[$];

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[9];

  imem_dmem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ready    (if_ready),
    .dm_read     (dm_read),
    .dm_write    (dm_write),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_ready    (dm_ready),
    .stall_if    (stall_if),
    .stall_mem   (stall_mem),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .dbg_state_o (dbg_state),
    .dbg_starve_o(dbg_starve)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: acks in the lat_cfg-th cycle of a held mem_req.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (mem_req === 1'b1 && ack_en) begin
        cnt++;
        if (cnt == lat_cfg) begin
          mem_ack = 1'b1;
          if (mem_we) mem_m[mem_addr] = mem_wdata;
          else        mem_rdata = mem_m[mem_addr];
        end
      end else begin
        cnt = 0;
      end
      if (manual_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Scoreboard and grant log, sampled on the falling edge.
  initial begin
    logic        prev_req;
    logic [31:0] e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (if_ready === 1'b1) begin
        if (if_exp_q.size() == 0) chk("if_ready_spurious", {31'b0, if_ready}, 32'd0);
        else begin
          e = if_exp_q.pop_front();
          chk("if_rdata", if_rdata, e);
        end
      end
      if (dm_ready === 1'b1) begin
        if (dm_exp_q.size() == 0) chk("dm_ready_spurious", {31'b0, dm_ready}, 32'd0);
        else begin
          e = dm_exp_q.pop_front();
          chk("dm_rdata", dm_rdata, e);
        end
      end
      if (mem_req === 1'b1 && !prev_req) begin
        grant_q.push_back((dbg_state == FETCH) ? 8'h46 : 8'h44);
        starve_q.push_back(dbg_starve);
      end
      prev_req = (mem_req === 1'b1);
    end
  end

  // Single transaction on one port, checking grant, stability, stalls and latency.
  task automatic do_txn(input int kind, input logic [7:0] a, input logic [31:0] wd,
                        input int lat, input logic [31:0] exp_d);
    int   n;
    bit   got;
    logic rdy, stl;
    lat_cfg = lat;
    if (kind == K_FETCH) begin
      if_req  = 1'b1;
      if_addr = a;
      if_exp_q.push_back(exp_d);
    end else begin
      dm_read  = (kind == K_LOAD) || (kind == K_BOTH);
      dm_write = (kind == K_STORE) || (kind == K_BOTH);
      dm_addr  = a;
      dm_wdata = wd;
      dm_exp_q.push_back(exp_d);
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (mem_req === 1'b1) got = 1'b1;
      else n++;
    end
    chk("grant_seen", {31'b0, got}, 32'd1);
    if (got) begin
      chk("mem_we", {31'b0, mem_we}, (kind >= K_STORE) ? 32'd1 : 32'd0);
      chk("mem_addr", {24'b0, mem_addr}, {24'b0, a});
      if (kind >= K_STORE) chk("mem_wdata", mem_wdata, wd);
      n   = 0;
      got = 1'b0;
      while (!got && n < 20) begin
        rdy = (kind == K_FETCH) ? if_ready : dm_ready;
        stl = (kind == K_FETCH) ? stall_if : stall_mem;
        if (rdy === 1'b1) begin
          got = 1'b1;
          chk("stall_at_ready", {31'b0, stl}, 32'd0);
          chk("mem_req_at_ready", {31'b0, mem_req}, 32'd0);
          chk("latency", 32'(n), 32'(lat));
        end else begin
          chk("stall_waiting", {31'b0, stl}, 32'd1);
          chk("mem_req_held", {31'b0, mem_req}, 32'd1);
          chk("mem_addr_stable", {24'b0, mem_addr}, {24'b0, a});
          if (kind >= K_STORE) chk("mem_wdata_stable", mem_wdata, wd);
          n++;
          @(negedge clk);
        end
      end
      chk("ready_seen", {31'b0, got}, 32'd1);
    end
    @(posedge clk);
    #1;
    if_req   = 1'b0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
  endtask

  // Fetch at 0x10 held while n_data back-to-back loads from 0x40.. compete for the port.
  task automatic run_conc(input int n_data);
    int dcount, cyc;
    bit fdone, dr, fr;
    dcount = 0;
    cyc    = 0;
    fdone  = 1'b0;
    grant_q.delete();
    starve_q.delete();
    lat_cfg = 1;
    if_exp_q.push_back(32'h8C22_0004);
    for (int i = 0; i < n_data; i++) dm_exp_q.push_back(32'h4000_0000 + 32'(i));
    if_req   = 1'b1;
    if_addr  = 8'h10;
    dm_read  = 1'b1;
    dm_write = 1'b0;
    dm_addr  = 8'h40;
    while ((dcount < n_data || !fdone) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      dr = (dm_ready === 1'b1);
      fr = (if_ready === 1'b1);
      @(posedge clk);
      #1;
      if (dr) begin
        dcount++;
        if (dcount < n_data) dm_addr = 8'h40 + 8'(dcount);
        else dm_read = 1'b0;
      end
      if (fr) begin
        fdone  = 1'b1;
        if_req = 1'b0;
      end
    end
    chk("conc_complete", {31'b0, (dcount == n_data) && fdone}, 32'd1);
  endtask

  initial begin
    logic [7:0]  exp_g[6];
    logic [7:0]  exp_s[6];
    logic [7:0]  ra;
    int          rk, rl;
    bit          seen;
    int          n;

    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    mem_m[8'h10] = 32'h8C22_0004;
    mem_m[8'h11] = 32'h2008_0005;
    for (int i = 0; i < 8; i++)  mem_m[8'h40 + i] = 32'h4000_0000 + 32'(i);
    for (int i = 0; i < 16; i++) mem_m[8'h80 + i] = 32'h8000_0080 + 32'(i);

    vecs[0] = '{K_FETCH, 8'h10, 32'h0,         2, 32'h8C22_0004};
    vecs[1] = '{K_STORE, 8'h20, 32'hDEAD_BEEF, 1, 32'h4000_0000};
    vecs[2] = '{K_LOAD,  8'h20, 32'h0,         1, 32'hDEAD_BEEF};
    vecs[3] = '{K_FETCH, 8'h11, 32'h0,         3, 32'h2008_0005};
    vecs[4] = '{K_BOTH,  8'h30, 32'hCAFE_F00D, 2, 32'hDEAD_BEEF};
    vecs[5] = '{K_LOAD,  8'h30, 32'h0,         4, 32'hCAFE_F00D};
    vecs[6] = '{K_FETCH, 8'h30, 32'h0,         1, 32'hCAFE_F00D};
    vecs[7] = '{K_STORE, 8'hFF, 32'h1234_5678, 1, 32'hCAFE_F00D};
    vecs[8] = '{K_LOAD,  8'hFF, 32'h0,         2, 32'h1234_5678};

    // Reset held with both requesters active
    reset    = 1'b1;
    if_req   = 1'b1;
    if_addr  = 8'h10;
    dm_read  = 1'b1;
    dm_write = 1'b0;
    dm_addr  = 8'h40;
    dm_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req",   {31'b0, mem_req},  32'd0);
    chk("rst_mem_we",    {31'b0, mem_we},   32'd0);
    chk("rst_mem_addr",  {24'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata,         32'd0);
    chk("rst_if_rdata",  if_rdata,          32'd0);
    chk("rst_dm_rdata",  dm_rdata,          32'd0);
    chk("rst_if_ready",  {31'b0, if_ready}, 32'd0);
    chk("rst_dm_ready",  {31'b0, dm_ready}, 32'd0);
    chk("rst_state",     32'(dbg_state),    32'(IDLE));
    chk("rst_starve",    {24'b0, dbg_starve}, 32'd0);
    chk("rst_stall_if",  {31'b0, stall_if}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_conc(1);
    chk("t1_grants", 32'(grant_q.size()), 32'd2);
    if (grant_q.size() == 2) begin
      chk("t1_first_grant", {24'b0, grant_q[0]}, 32'h44);
      chk("t1_second_grant", {24'b0, grant_q[1]}, 32'h46);
      chk("t1_starve_after_f", {24'b0, starve_q[1]}, 32'd0);
    end

    // Vector table: single-port transactions
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].exp_d);
    end

    // Random reads from the preloaded 0x80..0x8F region
    for (int i = 0; i < 6; i++) begin
      rk = $urandom_range(0, 1);
      ra = 8'h80 + 8'($urandom_range(0, 15));
      rl = $urandom_range(1, 4);
      do_txn(rk, ra, 32'h0, rl, 32'h8000_0000 | {24'b0, ra});
    end

    // Starvation: four data grants, then a forced fetch, then data again
    run_conc(5);
    exp_g = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h46, 8'h44};
    exp_s = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0};
    chk("t4_grants", 32'(grant_q.size()), 32'd6);
    if (grant_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("t4_grant_order", {24'b0, grant_q[i]}, {24'b0, exp_g[i]});
        chk("t4_starve", {24'b0, starve_q[i]}, {24'b0, exp_s[i]});
      end
    end

    // Reset during a data transaction, followed by a stray ack
    ack_en  = 1'b0;
    dm_read = 1'b1;
    dm_addr = 8'h50;
    seen    = 1'b0;
    n       = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (mem_req === 1'b1) seen = 1'b1;
      else n++;
    end
    chk("t5_req_seen", {31'b0, seen}, 32'd1);
    chk("t5_in_data", 32'(dbg_state), 32'(DATA));
    @(posedge clk);
    #1;
    reset   = 1'b1;
    dm_read = 1'b0;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    manual_ack = 1'b1;
    @(negedge clk);
    chk("t5_mem_req_cleared", {31'b0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    manual_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_dm_ready", {31'b0, dm_ready}, 32'd0);
      chk("t5_dm_rdata", dm_rdata, 32'd0);
      chk("t5_state_idle", 32'(dbg_state), 32'(IDLE));
      chk("t5_mem_req", {31'b0, mem_req}, 32'd0);
    end
    ack_en = 1'b1;

    // The port still works after the abort
    @(posedge clk);
    #1;
    do_txn(K_LOAD, 8'h41, 32'h0, 2, 32'h4000_0001);

    repeat (3) @(negedge clk);
    chk("if_exp_drained", 32'(if_exp_q.size()), 32'd0);
    chk("dm_exp_drained", 32'(dm_exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
